// File: rtl/dmx_frame_ctrl.sv
// DMX frame controller: maps a window of receiver slots onto PWM levels,
// double-buffers them, commits complete windows atomically and supervises signal loss.
module dmx_frame_ctrl #(
    parameter int unsigned NUM_OUTPUTS      = 8,
    parameter int unsigned CHANNEL_BITS     = 9,
    parameter int unsigned LOSS_TIMEOUT     = 48_000_000,
    parameter bit          BLACKOUT_ON_LOSS = 1'b1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      write_strobe,
    input  logic [CHANNEL_BITS-1:0]   channel,
    input  logic [7:0]                data,
    input  logic [CHANNEL_BITS-1:0]   base_address,
    output logic [NUM_OUTPUTS*8-1:0]  levels,
    output logic                      frame_commit,
    output logic                      signal_ok,
    output logic                      config_error,
    output logic [7:0]                short_frames
);

    localparam int unsigned CW = CHANNEL_BITS + 1;
    localparam int unsigned LW = NUM_OUTPUTS * 8;
    localparam int unsigned TW = $clog2(LOSS_TIMEOUT + 1);

    typedef enum logic [1:0] {
        WAIT_START = 2'd0,
        COLLECT    = 2'd1,
        COMMIT     = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [CHANNEL_BITS-1:0] base_q;
    logic [NUM_OUTPUTS-1:0]  mask;
    logic [LW-1:0]           shadow;
    logic [TW-1:0]           timer;

    logic                    frame_start;
    logic                    commit_go;
    logic                    map_en;
    logic                    timer_hit;
    logic                    cfg_next;
    logic [CHANNEL_BITS-1:0] base_eff;
    logic [CW-1:0]           offset;
    logic [CW-1:0]           window_end;
    logic [NUM_OUTPUTS-1:0]  hit;
    logic [NUM_OUTPUTS-1:0]  mask_next;

    // Next-state and slot-mapping decode.
    always_comb begin
        state_next  = state;
        frame_start = write_strobe && (channel == '0);
        commit_go   = (state == COLLECT) && (&mask) && !config_error;
        base_eff    = frame_start ? base_address : base_q;
        offset      = {1'b0, channel} - {1'b0, base_eff};
        // Writes are held off while the completed window is being handed over.
        map_en      = write_strobe && (frame_start || (state == COLLECT)) && !commit_go;
        hit         = '0;
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            hit[i] = map_en && (offset == CW'(i));
        end
        mask_next   = (frame_start ? '0 : mask) | hit;
        window_end  = {1'b0, base_address} + CW'(NUM_OUTPUTS - 1);
        cfg_next    = frame_start ? (window_end > {1'b0, {CHANNEL_BITS{1'b1}}}) : config_error;
        timer_hit   = (state != COMMIT) && (timer == TW'(LOSS_TIMEOUT - 1));

        case (state)
            WAIT_START: begin
                if (frame_start) state_next = COLLECT;
            end
            COLLECT: begin
                if (commit_go) state_next = COMMIT;
            end
            COMMIT: begin
                // A frame start during the hand-over cycle left the mask cleared.
                if (frame_start || !(&mask)) state_next = COLLECT;
                else                         state_next = WAIT_START;
            end
            default: state_next = WAIT_START;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) state <= WAIT_START;
        else        state <= state_next;
    end

    // Window tracking, shadow buffer and output registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            base_q       <= '0;
            mask         <= '0;
            shadow       <= '0;
            config_error <= 1'b0;
            short_frames <= 8'd0;
            timer        <= '0;
            levels       <= '0;
            frame_commit <= 1'b0;
            signal_ok    <= 1'b0;
        end else begin
            if (frame_start) base_q <= base_address;
            mask         <= mask_next;
            config_error <= cfg_next;
            for (int i = 0; i < NUM_OUTPUTS; i++) begin
                if (hit[i]) shadow[i*8 +: 8] <= data;
            end

            if (frame_start && (state == COLLECT) && !commit_go && (short_frames != 8'hFF))
                short_frames <= short_frames + 8'd1;

            if (state == COMMIT)                     timer <= '0;
            else if (timer != TW'(LOSS_TIMEOUT))     timer <= timer + TW'(1);

            frame_commit <= (state == COMMIT);

            // Commit takes priority over a coincident loss event.
            if (state == COMMIT) begin
                levels    <= shadow;
                signal_ok <= 1'b1;
            end else if (timer_hit) begin
                signal_ok <= 1'b0;
                if (BLACKOUT_ON_LOSS) levels <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dmx_frame_ctrl.sv
// Directed self-checking bench for dmx_frame_ctrl (4 outputs, 100-cycle loss timeout, blackout on).
module tb_dmx_frame_ctrl;

    localparam int unsigned NO = 4;
    localparam int unsigned CB = 9;
    localparam int unsigned LT = 100;

    logic          clock;
    logic          reset;
    logic          write_strobe;
    logic [CB-1:0] channel;
    logic [7:0]    data;
    logic [CB-1:0] base_address;
    logic [NO*8-1:0] levels;
    logic          frame_commit;
    logic          signal_ok;
    logic          config_error;
    logic [7:0]    short_frames;

    int total;
    int bad;
    int cyc;
    int commit_count;
    int commit_cyc;
    int mark_cyc;

    dmx_frame_ctrl #(
        .NUM_OUTPUTS(NO), .CHANNEL_BITS(CB), .LOSS_TIMEOUT(LT), .BLACKOUT_ON_LOSS(1'b1)
    ) dut (
        .clock(clock), .reset(reset), .write_strobe(write_strobe), .channel(channel),
        .data(data), .base_address(base_address), .levels(levels),
        .frame_commit(frame_commit), .signal_ok(signal_ok), .config_error(config_error),
        .short_frames(short_frames)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (frame_commit) begin
            commit_count = commit_count + 1;
            commit_cyc   = cyc;
        end
    end

    task automatic send(input int ch, input int d, input bit mark);
        @(negedge clock);
        write_strobe = 1'b1;
        channel      = CB'(ch);
        data         = 8'(d);
        if (mark) mark_cyc = cyc + 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            write_strobe = 1'b0;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        idle(3);
        total++; if (levels !== '0) begin bad++; $display("FAIL reset_levels got=%h want=0", levels); end
        total++; if (frame_commit !== 1'b0) begin bad++; $display("FAIL reset_commit got=%b want=0", frame_commit); end
        total++; if (signal_ok !== 1'b0) begin bad++; $display("FAIL reset_signal_ok got=%b want=0", signal_ok); end
        total++; if (config_error !== 1'b0) begin bad++; $display("FAIL reset_cfg got=%b want=0", config_error); end
        total++; if (short_frames !== 8'd0) begin bad++; $display("FAIL reset_short got=%0d want=0", short_frames); end
        reset = 1'b1;
        idle(2);
    endtask

    task automatic test_basic;
        int c0;
        c0 = commit_count;
        base_address = CB'(10);
        for (int ch = 0; ch <= 20; ch++) send(ch, ch + 1, ch == 13);
        idle(4);
        total++; if (commit_count !== c0 + 1) begin bad++; $display("FAIL basic_count got=%0d want=%0d", commit_count - c0, 1); end
        total++; if (commit_cyc - mark_cyc !== 2) begin bad++; $display("FAIL basic_latency got=%0d want=2", commit_cyc - mark_cyc); end
        total++; if (levels !== {8'd14, 8'd13, 8'd12, 8'd11}) begin bad++; $display("FAIL basic_levels got=%h want=0e0d0c0b", levels); end
        total++; if (signal_ok !== 1'b1) begin bad++; $display("FAIL basic_signal_ok got=%b want=1", signal_ok); end
        total++; if (frame_commit !== 1'b0) begin bad++; $display("FAIL basic_pulse got=%b want=0", frame_commit); end
    endtask

    task automatic test_short_frame;
        int c0;
        c0 = commit_count;
        base_address = CB'(10);
        for (int ch = 0; ch <= 11; ch++) send(ch, ch + 100, 1'b0);
        send(0, 0, 1'b0);
        idle(3);
        total++; if (short_frames !== 8'd1) begin bad++; $display("FAIL short_count got=%0d want=1", short_frames); end
        total++; if (commit_count !== c0) begin bad++; $display("FAIL short_no_commit got=%0d want=0", commit_count - c0); end
        total++; if (levels !== {8'd14, 8'd13, 8'd12, 8'd11}) begin bad++; $display("FAIL short_levels got=%h want=0e0d0c0b", levels); end
        for (int ch = 1; ch <= 15; ch++) send(ch, ch + 50, 1'b0);
        idle(4);
        total++; if (commit_count !== c0 + 1) begin bad++; $display("FAIL short_follow_count got=%0d want=1", commit_count - c0); end
        total++; if (levels !== {8'd63, 8'd62, 8'd61, 8'd60}) begin bad++; $display("FAIL short_follow_levels got=%h want=3f3e3d3c", levels); end
        total++; if (short_frames !== 8'd1) begin bad++; $display("FAIL short_follow_short got=%0d want=1", short_frames); end
    endtask

    task automatic test_back_to_back;
        int c0;
        c0 = commit_count;
        base_address = CB'(0);
        send(0, 200, 1'b0);
        send(1, 201, 1'b0);
        send(2, 202, 1'b0);
        base_address = CB'(5);
        send(3, 203, 1'b1);
        idle(4);
        total++; if (commit_count !== c0 + 1) begin bad++; $display("FAIL b2b_count got=%0d want=1", commit_count - c0); end
        total++; if (commit_cyc - mark_cyc !== 2) begin bad++; $display("FAIL b2b_latency got=%0d want=2", commit_cyc - mark_cyc); end
        total++; if (levels !== {8'd203, 8'd202, 8'd201, 8'd200}) begin bad++; $display("FAIL b2b_levels got=%h want=cbcac9c8", levels); end
        for (int ch = 0; ch <= 10; ch++) send(ch, ch + 20, 1'b0);
        idle(4);
        total++; if (commit_count !== c0 + 2) begin bad++; $display("FAIL b2b_rebase_count got=%0d want=2", commit_count - c0); end
        total++; if (levels !== {8'd28, 8'd27, 8'd26, 8'd25}) begin bad++; $display("FAIL b2b_rebase_levels got=%h want=1c1b1a19", levels); end
    endtask

    task automatic test_config_error;
        int c0;
        c0 = commit_count;
        base_address = CB'(510);
        for (int ch = 0; ch <= 511; ch++) send(ch, ch & 255, 1'b0);
        idle(4);
        total++; if (config_error !== 1'b1) begin bad++; $display("FAIL cfg_set got=%b want=1", config_error); end
        total++; if (commit_count !== c0) begin bad++; $display("FAIL cfg_no_commit got=%0d want=0", commit_count - c0); end
        total++; if (signal_ok !== 1'b0) begin bad++; $display("FAIL cfg_loss_ok got=%b want=0", signal_ok); end
        total++; if (levels !== '0) begin bad++; $display("FAIL cfg_blackout got=%h want=0", levels); end
        base_address = CB'(500);
        for (int ch = 0; ch <= 511; ch++) send(ch, ch & 255, 1'b0);
        idle(4);
        total++; if (config_error !== 1'b0) begin bad++; $display("FAIL cfg_clear got=%b want=0", config_error); end
        total++; if (commit_count !== c0 + 1) begin bad++; $display("FAIL cfg_commit got=%0d want=1", commit_count - c0); end
        total++; if (levels !== {8'd247, 8'd246, 8'd245, 8'd244}) begin bad++; $display("FAIL cfg_levels got=%h want=f7f6f5f4", levels); end
        total++; if (short_frames !== 8'd2) begin bad++; $display("FAIL cfg_short got=%0d want=2", short_frames); end
        total++; if (signal_ok !== 1'b1) begin bad++; $display("FAIL cfg_signal_ok got=%b want=1", signal_ok); end
    endtask

    task automatic test_signal_loss;
        int drop_cyc;
        int n;
        base_address = CB'(0);
        for (int ch = 0; ch <= 3; ch++) send(ch, ch + 1, 1'b0);
        idle(3);
        total++; if (levels !== {8'd4, 8'd3, 8'd2, 8'd1}) begin bad++; $display("FAIL loss_pre_levels got=%h want=04030201", levels); end
        drop_cyc = -1;
        n = 0;
        while (n < 150 && drop_cyc < 0) begin
            @(negedge clock);
            n++;
            if (!signal_ok) drop_cyc = cyc;
            if (n == 50) begin
                total++; if (levels !== {8'd4, 8'd3, 8'd2, 8'd1}) begin bad++; $display("FAIL loss_hold got=%h want=04030201", levels); end
            end
        end
        total++; if (drop_cyc < 0) begin bad++; $display("FAIL loss_timeout got=no_drop want=drop"); end
        total++; if (drop_cyc >= 0 && (drop_cyc - commit_cyc < 99 || drop_cyc - commit_cyc > 101)) begin
            bad++; $display("FAIL loss_delay got=%0d want=100", drop_cyc - commit_cyc);
        end
        total++; if (levels !== '0) begin bad++; $display("FAIL loss_blackout got=%h want=0", levels); end
        for (int ch = 0; ch <= 3; ch++) send(ch, ch + 9, 1'b0);
        idle(4);
        total++; if (signal_ok !== 1'b1) begin bad++; $display("FAIL loss_restore got=%b want=1", signal_ok); end
        total++; if (levels !== {8'd12, 8'd11, 8'd10, 8'd9}) begin bad++; $display("FAIL loss_restore_levels got=%h want=0c0b0a09", levels); end
    endtask

    task automatic test_reset_mid_frame;
        int c0;
        base_address = CB'(10);
        for (int ch = 0; ch <= 11; ch++) send(ch, ch + 1, 1'b0);
        @(negedge clock);
        write_strobe = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        c0 = commit_count;
        send(12, 13, 1'b0);
        send(13, 14, 1'b0);
        idle(5);
        total++; if (commit_count !== c0) begin bad++; $display("FAIL rst_mid_commit got=%0d want=0", commit_count - c0); end
        total++; if (levels !== '0) begin bad++; $display("FAIL rst_mid_levels got=%h want=0", levels); end
        total++; if (signal_ok !== 1'b0) begin bad++; $display("FAIL rst_mid_ok got=%b want=0", signal_ok); end
        total++; if (short_frames !== 8'd0) begin bad++; $display("FAIL rst_mid_short got=%0d want=0", short_frames); end
        total++; if (config_error !== 1'b0) begin bad++; $display("FAIL rst_mid_cfg got=%b want=0", config_error); end
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        cyc          = 0;
        commit_count = 0;
        commit_cyc   = 0;
        mark_cyc     = 0;
        reset        = 1'b0;
        write_strobe = 1'b0;
        channel      = '0;
        data         = 8'd0;
        base_address = '0;
        test_reset();
        test_basic();
        test_short_frame();
        test_back_to_back();
        test_config_error();
        test_signal_loss();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmx_frame_ctrl.md
# dmx_frame_ctrl

Frame-level controller between the DMX receiver and the PWM channel bank. It consumes the receiver's per-slot write stream (`write_strobe`, `channel`, `data`) and selects a window of `NUM_OUTPUTS` consecutive slots starting at a configurable base address. It double-buffers those slots and commits them to the PWM levels atomically, only once a complete window has been received. It also supervises signal loss and can black out the outputs on loss.

## Interface
- `NUM_OUTPUTS`, 8: number of mapped slots / PWM outputs (1..64).
- `CHANNEL_BITS`, 9: width of the slot index; matches the receiver's channel bus (512 slots).
- `LOSS_TIMEOUT`, 48_000_000: clock cycles without a commit before signal is declared lost (1 s at 48 MHz).
- `BLACKOUT_ON_LOSS`, 1: 1 = zero all levels on loss; 0 = hold last committed look.
- `clock` in 1: system clock; everything is on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `write_strobe` in 1: one-cycle pulse from the receiver; `channel`/`data` are valid while it is high.
- `channel` in `CHANNEL_BITS`: 0-based data slot index; the start code is excluded, so DMX address 1 = 0.
- `data` in 8: slot value.
- `base_address` in `CHANNEL_BITS`: 0-based first mapped slot; sampled only at frame start.
- `levels` out `NUM_OUTPUTS*8`: committed levels; output i is at bits [8i+7:8i].
- `frame_commit` out 1: one-cycle pulse in the first cycle new `levels` are visible.
- `signal_ok` out 1: high after a commit; low after loss timeout.
- `config_error` out 1: latched base window exceeds the slot space.
- `short_frames` out 8: saturating count of abandoned (incomplete) frames.

## Operation
- State machine: WAIT_START, COLLECT, COMMIT. Reset state is WAIT_START.
- Frame start = any strobe with `channel == 0`, in any state. On frame start:
  - latch `base_address` into `base_q`;
  - clear the received-mask (`NUM_OUTPUTS` bits);
  - set `config_error` ← (`base_address + NUM_OUTPUTS - 1 > 2^CHANNEL_BITS - 1`), evaluated at `CHANNEL_BITS+1`-bit width;
  - go to COLLECT.
- Frame start while in COLLECT abandons the current frame: `short_frames` += 1, saturating at 255. The shadow buffer is not copied.
- COLLECT, on a strobe with `channel - base_q` in [0, `NUM_OUTPUTS`-1] (unsigned, `CHANNEL_BITS+1` bits):
  - write `shadow[idx] ← data`;
  - set `mask[idx]`.
- The strobe that starts a frame is also mapped in the same cycle if `base_q == 0`.
- When the mask becomes all ones (a mapped strobe completes it) → COMMIT. The last slot is not required to arrive last.
- COMMIT (exactly one cycle):
  - `levels ← shadow`, `frame_commit ← 1`, `signal_ok ← 1`;
  - clear the loss timer;
  - → WAIT_START.
  - A channel-0 strobe in the COMMIT cycle is still processed as a frame start, so the next state is COLLECT.
- Strobes outside the window, and any non-zero strobe in WAIT_START, are ignored.
- While `config_error` = 1, no commit can occur; strobes are still tracked as above.
- Loss timer, `ceil(log2(LOSS_TIMEOUT+1))` bits:
  - increments every cycle and saturates at `LOSS_TIMEOUT`;
  - on reaching `LOSS_TIMEOUT`: `signal_ok ← 0`; if `BLACKOUT_ON_LOSS`, `levels ← 0`, applied once.
  - If the timer reaches its limit in the same cycle as COMMIT, COMMIT wins: the timer is cleared and `signal_ok` stays 1.
- Reset values: `levels` = 0, `frame_commit` = 0, `signal_ok` = 0, `config_error` = 0, `short_frames` = 0, shadow = 0, mask = 0, timer = 0, state = WAIT_START.
- Reset mid-frame discards the frame; the first commit after reset requires a fresh channel-0 strobe.

## Timing
- A strobe sampled at edge N is written to shadow at edge N.
- If that strobe completes the mask, COMMIT is the state during cycle N+1. `levels`/`frame_commit` update at edge N+2: latency 2 clocks from the completing strobe.
- `frame_commit` is high for exactly one cycle per complete window.
- Back-to-back strobes on consecutive cycles must be accepted; the block does not rely on DMX slot spacing.
- Signal loss is flagged `LOSS_TIMEOUT` cycles after the last commit edge (or after reset release), ±1 cycle.
- No combinational path from inputs to outputs.

## Test plan
- Basic frame:
  - stimulus: `base_address`=10, `NUM_OUTPUTS`=4, strobes ch0..ch20 with data = ch+1;
  - required: one `frame_commit` 2 cycles after the ch13 strobe; `levels` = {14,13,12,11} (output 3..0); `signal_ok`=1.
- Short frame:
  - stimulus: `base_address`=10, strobes ch0..ch11, then ch0 again;
  - required: `short_frames`=1, no commit, `levels` unchanged; a following full frame commits normally.
- Base at 0 with back-to-back strobes:
  - stimulus: `base_address`=0, strobes ch0..ch3 on consecutive cycles;
  - required: commit 2 cycles after ch3; `base_address` changed mid-frame to 5 has no effect until the next ch0.
- Config error:
  - stimulus: `base_address`=510, `NUM_OUTPUTS`=4, full 512-slot frame;
  - required: `config_error`=1, no `frame_commit`; setting `base_address`=500 and the next ch0 clears the error, and the frame commits.
- Signal loss:
  - stimulus: `LOSS_TIMEOUT`=100, one commit, then silence;
  - required: `signal_ok` drops ~100 cycles later and `levels`=0 (`BLACKOUT_ON_LOSS`=1), or held (`BLACKOUT_ON_LOSS`=0); the next full frame restores `signal_ok`=1.
- Reset mid-frame:
  - stimulus: assert `reset` low for 1 cycle after ch11 of a base-10 frame, then send ch12..ch13;
  - required: no commit, all outputs at reset values; `short_frames` not incremented.
